sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised sprite-drawing engine that copies a width/height-headed sprite image from a synchronous ROM port to the LT24Display pixel interface at a latched screen origin. It adds a configurable ROM read latency, base-address sprite selection, horizontal/vertical mirroring, a programmable transparent colour key and screen-edge clipping. It sits between the game/demo control logic (start/busy/done) and the LT24Display pixel port and ROM multiplexer.

## Interface
- `X_WIDTH`, 8: x coordinate width.
- `Y_WIDTH`, 9: y coordinate width.
- `LCD_WIDTH`, 240: visible columns; pixels with x >= this are clipped.
- `LCD_HEIGHT`, 320: visible rows; pixels with y >= this are clipped.
- `ADDR_WIDTH`, 16: ROM word address width.
- `ROM_LATENCY`, 2: clock edges from `romAddr` change until `romData` is valid (>= 1).
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request a draw; accepted only in IDLE.
- `xOrigin`  in  X_WIDTH  screen x of the sprite's top-left pixel; latched on accept.
- `yOrigin`  in  Y_WIDTH  screen y of the top-left pixel; latched on accept.
- `baseAddr`  in  ADDR_WIDTH  ROM address of the sprite header; latched on accept.
- `flipX`, `flipY`  in  1 each  mirror columns/rows; latched on accept.
- `keyColour`  in  16  transparent colour; latched on accept.
- `busy`  out  1  high from accept until done.
- `done`  out  1  one-cycle pulse when a draw finishes.
- `romAddr`  out  ADDR_WIDTH  ROM read address.
- `romData`  in  16  ROM read data.
- `xAddr`  out  X_WIDTH, `yAddr` out Y_WIDTH, `pixelData` out 16: pixel write payload.
- `pixelWrite`  out  1  write request.
- `pixelReady`  in  1  display accepts the write.

## Operation
- Sprite format at `baseAddr`: word 0 = width W (bits [7:0]); word 1 = height H (bits [8:0]); then W*H colour words, row-major, row 0 first, column 0 first.
- States: IDLE -> RD_W -> RD_H -> FETCH -> WRITE -> NEXT -> FETCH ... -> DONE -> IDLE.
- IDLE: busy=0. On `start`=1, latch all inputs, set busy=1, romAddr=baseAddr, go to RD_W.
- RD_W / RD_H / FETCH: hold romAddr for ROM_LATENCY cycles, then capture romData. RD_W drives baseAddr; RD_H drives baseAddr+1; pixel c,r uses baseAddr+2+r*W+c, tracked by an incrementing pointer (no multiplier).
- If W=0 or H=0 after RD_H: go straight to DONE; no pixel writes.
- Destination: x = xOrigin + (flipX ? W-1-c : c); y = yOrigin + (flipY ? H-1-r : r). Sums are computed one bit wider than the coordinate width.
- A pixel is skipped (no write, straight to NEXT) if its colour == keyColour, x >= LCD_WIDTH, or y >= LCD_HEIGHT. This covers both sum overflow and off-screen cases.
- WRITE: drive xAddr/yAddr/pixelData and pixelWrite=1. Hold them until a cycle with pixelReady=1; the write transfers on that edge. pixelWrite then drops to 0 and the block moves to NEXT.
- NEXT: c+1 if c<W-1; otherwise c=0, r+1 if r<H-1; otherwise go to DONE. Pointer always +1.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- `start` is ignored while busy. A `start` held high at DONE->IDLE starts a new draw on the next IDLE cycle.

## Timing
- Reset values: busy=0, done=0, pixelWrite=0, romAddr=0, xAddr=0, yAddr=0, pixelData=0; state IDLE.
- Reset mid-draw aborts immediately: pixelWrite falls asynchronously and no further writes occur.
- Accept edge = T. Width is captured at T+ROM_LATENCY. Height is captured ROM_LATENCY+1 cycles later.
- Each pixel costs ROM_LATENCY+1 fetch/next cycles, plus write cycles (at least 1, and more while pixelReady=0).
- Inputs changing while busy have no effect on the draw in progress.
- pixelWrite is never high in two consecutive writes without an intervening low cycle.

## Test plan
- Reset: hold reset=0 with start=1 -> all outputs 0, no ROM activity. Release -> IDLE, busy=0.
- 2x2 sprite at base 0x0010, words {2,2,A,B,C,D}, origin (10,20), pixelReady always 1, key 0x0001 -> writes (10,20)=A, (11,20)=B, (10,21)=C, (11,21)=D in order; one done pulse.
- Same sprite with flipX=1, flipY=1 -> writes (11,21)=A, (10,21)=B, (11,20)=C, (10,20)=D.
- Transparency and clipping: 3x1 sprite {B,0x0001,C} at x=238, key 0x0001 -> only (238,y)=B is written; the keyed pixel and x=240 are skipped.
- Backpressure and latency: pixelReady low 5 cycles per write, ROM_LATENCY=3 -> payload stable while waiting; exactly one transfer per pixel; correct data.
- Zero height: header {4,0} -> no writes; done pulse 2*ROM_LATENCY+2 cycles after accept.
- Reset asserted during the 2nd WRITE -> pixelWrite drops immediately. After release, a new start draws correctly from pixel 0.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a {W,H,pixels} sprite from a synchronous ROM to the LT24 pixel port.
// Latency: header takes 2*ROM_LATENCY+1 cycles; each pixel takes ROM_LATENCY+1 cycles plus its write cycles.
// Backpressure: WRITE holds xAddr/yAddr/pixelData with pixelWrite=1 until pixelReady; start is ignored while busy.
//
// Ports: clock/reset (async active-low); start/busy/done control handshake;
//        xOrigin/yOrigin/baseAddr/flipX/flipY/keyColour draw setup (latched on accept);
//        romAddr/romData ROM read port; xAddr/yAddr/pixelData/pixelWrite/pixelReady pixel write port.
module sprite_blitter #(
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 9,
  parameter int LCD_WIDTH   = 240,
  parameter int LCD_HEIGHT  = 320,
  parameter int ADDR_WIDTH  = 16,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [X_WIDTH-1:0]    xOrigin,
  input  logic [Y_WIDTH-1:0]    yOrigin,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic                  flipX,
  input  logic                  flipY,
  input  logic [15:0]           keyColour,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] romAddr,
  input  logic [15:0]           romData,
  output logic [X_WIDTH-1:0]    xAddr,
  output logic [Y_WIDTH-1:0]    yAddr,
  output logic [15:0]           pixelData,
  output logic                  pixelWrite,
  input  logic                  pixelReady
);

  localparam int XS = X_WIDTH + 1;
  localparam int YS = Y_WIDTH + 1;
  localparam int CW = $clog2(ROM_LATENCY + 1) + 1;
  localparam logic [CW-1:0] LAT    = CW'(ROM_LATENCY);
  localparam logic [CW-1:0] LAT_M1 = CW'(ROM_LATENCY - 1);
  localparam logic [XS-1:0] X_LIM  = XS'(LCD_WIDTH);
  localparam logic [YS-1:0] Y_LIM  = YS'(LCD_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_W, S_RD_H, S_FETCH, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [X_WIDTH-1:0]    r_x0;
  logic [Y_WIDTH-1:0]    r_y0;
  logic                  r_flip_x;
  logic                  r_flip_y;
  logic [15:0]           r_key;
  logic [7:0]            r_w;
  logic [8:0]            r_h;
  logic [7:0]            r_c;
  logic [8:0]            r_r;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [X_WIDTH-1:0]    r_x_addr;
  logic [Y_WIDTH-1:0]    r_y_addr;
  logic [15:0]           r_pix;

  logic                  w_lat_done;
  logic                  w_hdr_done;
  logic [7:0]            w_col;
  logic [8:0]            w_row;
  logic [XS-1:0]         w_x;
  logic [YS-1:0]         w_y;
  logic                  w_skip;
  logic                  w_last;
  logic                  w_empty;

  assign w_lat_done = (r_cnt == LAT_M1);
  // Height is taken one cycle later than a plain fetch, fixing the header
  // phase at 2*ROM_LATENCY+1 cycles.
  assign w_hdr_done = (r_cnt == LAT);

  // Mirrored source column/row feed the destination sums, one bit wider than
  // the coordinate so overflow past the screen edge shows up as a clip.
  assign w_col   = r_flip_x ? (r_w - 8'd1 - r_c) : r_c;
  assign w_row   = r_flip_y ? (r_h - 9'd1 - r_r) : r_r;
  assign w_x     = XS'(r_x0) + XS'(w_col);
  assign w_y     = YS'(r_y0) + YS'(w_row);
  assign w_skip  = (romData == r_key) || (w_x >= X_LIM) || (w_y >= Y_LIM);
  assign w_last  = (r_c == r_w - 8'd1) && (r_r == r_h - 9'd1);
  assign w_empty = (r_w == 8'd0) || (romData[8:0] == 9'd0);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_next = S_RD_W;
      S_RD_W:  if (w_lat_done) w_next = S_RD_H;
      S_RD_H:  if (w_hdr_done) w_next = w_empty ? S_DONE : S_FETCH;
      S_FETCH: if (w_lat_done) w_next = w_skip ? S_NEXT : S_WRITE;
      S_WRITE: if (pixelReady) w_next = S_NEXT;
      S_NEXT:  w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state, so reset drops pixelWrite without a clock.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    pixelWrite = 1'b0;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_DONE:  done = 1'b1;
      S_WRITE: begin
        busy       = 1'b1;
        pixelWrite = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // Wait counter for ROM latency; restarts on every state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((r_state == S_RD_W || r_state == S_RD_H || r_state == S_FETCH)
                 && (w_next == r_state)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Datapath. romAddr doubles as the pixel pointer: base, base+1, then
  // base+2 onward stepping by one per pixel in row-major order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_flip_x   <= 1'b0;
      r_flip_y   <= 1'b0;
      r_key      <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_c        <= '0;
      r_r        <= '0;
      r_rom_addr <= '0;
      r_x_addr   <= '0;
      r_y_addr   <= '0;
      r_pix      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x0       <= xOrigin;
          r_y0       <= yOrigin;
          r_flip_x   <= flipX;
          r_flip_y   <= flipY;
          r_key      <= keyColour;
          r_rom_addr <= baseAddr;
          r_c        <= '0;
          r_r        <= '0;
        end
        S_RD_W: if (w_lat_done) begin
          r_w        <= romData[7:0];
          r_rom_addr <= r_rom_addr + 1'b1;
        end
        S_RD_H: if (w_hdr_done) begin
          r_h        <= romData[8:0];
          r_rom_addr <= r_rom_addr + 1'b1;
        end
        S_FETCH: if (w_lat_done && !w_skip) begin
          r_x_addr <= w_x[X_WIDTH-1:0];
          r_y_addr <= w_y[Y_WIDTH-1:0];
          r_pix    <= romData;
        end
        S_NEXT: begin
          r_rom_addr <= r_rom_addr + 1'b1;
          if (r_c < r_w - 8'd1) begin
            r_c <= r_c + 8'd1;
          end else begin
            r_c <= '0;
            if (r_r < r_h - 9'd1) r_r <= r_r + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign romAddr   = r_rom_addr;
  assign xAddr     = r_x_addr;
  assign yAddr     = r_y_addr;
  assign pixelData = r_pix;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a latency-3 ROM model and randomized sprites.
module tb_sprite_blitter;
  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  xOrigin = '0;
  logic [8:0]  yOrigin = '0;
  logic [15:0] baseAddr = '0;
  logic        flipX = 1'b0;
  logic        flipY = 1'b0;
  logic [15:0] keyColour = '0;
  logic        busy, done, pixelWrite;
  logic [15:0] romAddr, romData, pixelData;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic        pixelReady = 1'b0;

  sprite_blitter #(.ROM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .xOrigin(xOrigin), .yOrigin(yOrigin), .baseAddr(baseAddr),
    .flipX(flipX), .flipY(flipY), .keyColour(keyColour),
    .busy(busy), .done(done), .romAddr(romAddr), .romData(romData),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ROM: data for an address is usable at the LAT-th edge after it is presented.
  logic [15:0] mem [0:65535];
  logic [15:0] rom_p0, rom_p1;
  always @(posedge clock) begin
    rom_p0 <= mem[romAddr];
    rom_p1 <= rom_p0;
  end
  assign romData = rom_p1;

  typedef struct {int x; int y; logic [15:0] d;} exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;
  int stall = 0;
  int xfers = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic prev_xfer = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // pixelReady patterns: 0 always, 1 random, 2 five low cycles per write,
  // 3 accept only the first write then stall.
  always @(negedge clock) begin
    case (ready_mode)
      0: pixelReady = 1'b1;
      1: pixelReady = 1'($urandom_range(0, 1));
      2: begin
        if (pixelWrite) begin
          if (stall < 5) begin pixelReady = 1'b0; stall++; end
          else begin pixelReady = 1'b1; stall = 0; end
        end else begin
          pixelReady = 1'b0; stall = 0;
        end
      end
      default: pixelReady = (xfers == 0);
    endcase
  end

  // Monitor: compares every presented write payload with the scoreboard head.
  always @(negedge clock) begin
    #1;
    if (prev_xfer) chk("write_gap", int'(pixelWrite), 0);
    if (pixelWrite) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("wr_x", int'(xAddr), q[0].x);
        chk("wr_y", int'(yAddr), q[0].y);
        chk("wr_data", int'(pixelData), int'(q[0].d));
        if (pixelReady) begin
          void'(q.pop_front());
          xfers++;
        end
      end
    end
    prev_xfer = pixelWrite && pixelReady;
    if (done) begin
      chk("done_single_cycle", int'(prev_done), 0);
      done_cnt++;
      done_cyc = cyc;
    end
    prev_done = done;
  end

  // Reference model: walks the sprite in output order and applies the key/clip rules.
  task automatic build_expect(input int base, input int xo, input int yo, input bit fx,
                              input bit fy, input logic [15:0] key,
                              output int npix, output int nwr);
    int w, h, x, y;
    logic [15:0] col, hw, hh;
    hw = mem[16'(base)];
    hh = mem[16'(base + 1)];
    w = int'(hw[7:0]);
    h = int'(hh[8:0]);
    nwr = 0;
    npix = (w == 0 || h == 0) ? 0 : w * h;
    for (int r = 0; r < h && w > 0; r++) begin
      for (int c = 0; c < w; c++) begin
        col = mem[16'(base + 2 + r * w + c)];
        x = xo + (fx ? w - 1 - c : c);
        y = yo + (fy ? h - 1 - r : r);
        if (col != key && x < 240 && y < 320) begin
          q.push_back('{x, y, col});
          nwr++;
        end
      end
    end
  endtask

  task automatic issue(input int base, input int xo, input int yo, input bit fx,
                       input bit fy, input logic [15:0] key, output int acc);
    @(negedge clock);
    xOrigin = 8'(xo); yOrigin = 9'(yo); baseAddr = 16'(base);
    flipX = fx; flipY = fy; keyColour = key;
    start = 1'b1;
    chk("busy_before_accept", int'(busy), 0);
    acc = cyc;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    // Scramble inputs; the latched copies must be used for the whole draw.
    xOrigin = 8'($urandom); yOrigin = 9'($urandom); baseAddr = 16'($urandom);
    flipX = 1'($urandom); flipY = 1'($urandom); keyColour = 16'($urandom);
  endtask

  // wcost = cycles per write for a timing check (0 = no timing check).
  task automatic run_draw(input int base, input int xo, input int yo, input bit fx,
                          input bit fy, input logic [15:0] key, input int mode, input int wcost);
    int npix, nwr, acc, d0;
    q.delete();
    build_expect(base, xo, yo, fx, fy, key, npix, nwr);
    ready_mode = mode;
    xfers = 0;
    d0 = done_cnt;
    issue(base, xo, yo, fx, fy, key, acc);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clock);
    chk("done_seen", done_cnt - d0, 1);
    if (wcost > 0)
      chk("draw_cycles", done_cyc - acc, 2 * LAT + 2 + npix * (LAT + 1) + nwr * wcost);
    repeat (2) @(negedge clock);
    chk("expected_left", q.size(), 0);
    chk("transfers", xfers, nwr);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic load4(input int base, input int w, input int h, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    mem[16'(base)] = 16'(w); mem[16'(base + 1)] = 16'(h);
    mem[16'(base + 2)] = a; mem[16'(base + 3)] = b;
    mem[16'(base + 4)] = c; mem[16'(base + 5)] = d;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, w, h, base, xo, yo, npix, nwr;
    logic [15:0] key;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;

    // Reset held with start high.
    reset = 1'b0; start = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pixelWrite", int'(pixelWrite), 0);
    chk("rst_romAddr", int'(romAddr), 0);
    chk("rst_xAddr", int'(xAddr), 0);
    chk("rst_yAddr", int'(yAddr), 0);
    chk("rst_pixelData", int'(pixelData), 0);
    start = 1'b0;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_busy", int'(busy), 0);
    chk("idle_romAddr", int'(romAddr), 0);

    // Basic 2x2, then mirrored.
    load4(16'h0010, 2, 2, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD);
    run_draw(16'h0010, 10, 20, 0, 0, 16'h0001, 0, 1);
    run_draw(16'h0010, 10, 20, 1, 1, 16'h0001, 0, 1);

    // Transparency and right-edge clip.
    mem[16'h0040] = 16'd3; mem[16'h0041] = 16'd1;
    mem[16'h0042] = 16'h00BB; mem[16'h0043] = 16'h0001; mem[16'h0044] = 16'h00CC;
    run_draw(16'h0040, 238, 50, 0, 0, 16'h0001, 0, 1);

    // Backpressure: five stall cycles per write.
    load4(16'h0080, 2, 2, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    run_draw(16'h0080, 5, 6, 0, 1, 16'h0001, 2, 6);

    // Zero height and zero width headers (upper header bits set, ignored).
    mem[16'h00A0] = 16'hFF04; mem[16'h00A1] = 16'hFE00;
    run_draw(16'h00A0, 1, 1, 0, 0, 16'h0001, 0, 1);
    mem[16'h00B0] = 16'h0000; mem[16'h00B1] = 16'd3;
    run_draw(16'h00B0, 1, 1, 0, 0, 16'h0001, 0, 1);

    // Bottom-edge clip with y overflow past the screen.
    load4(16'h00C0, 2, 2, 16'h0111, 16'h0222, 16'h0333, 16'h0444);
    run_draw(16'h00C0, 100, 319, 0, 0, 16'h0000, 0, 1);

    // Randomized sprites.
    for (int t = 0; t < 12; t++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 5);
      base = 16'h1000 + t * 16'h0100;
      mem[16'(base)]     = {8'($urandom), 8'(w)};
      mem[16'(base + 1)] = {7'($urandom), 9'(h)};
      for (int k = 0; k < w * h; k++) mem[16'(base + 2 + k)] = 16'h1000 + 16'($urandom_range(0, 3));
      key = 16'h1000 + 16'($urandom_range(0, 7));
      xo = ($urandom_range(0, 1) == 1) ? $urandom_range(228, 255) : $urandom_range(0, 227);
      yo = ($urandom_range(0, 1) == 1) ? $urandom_range(310, 511) : $urandom_range(0, 309);
      if (t % 2 == 0)
        run_draw(base, xo, yo, 1'($urandom), 1'($urandom), key, 0, 1);
      else
        run_draw(base, xo, yo, 1'($urandom), 1'($urandom), key, 1, 0);
    end

    // Reset during the second write, then a clean redraw.
    load4(16'h0300, 2, 2, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    q.delete();
    build_expect(16'h0300, 100, 100, 0, 0, 16'h0000, npix, nwr);
    xfers = 0;
    ready_mode = 3;
    issue(16'h0300, 100, 100, 0, 0, 16'h0000, acc);
    for (int i = 0; i < 500 && !(xfers == 1 && pixelWrite); i++) @(negedge clock);
    chk("second_write_pending", int'(xfers == 1 && pixelWrite), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_pixelWrite", int'(pixelWrite), 0);
    chk("abort_busy", int'(busy), 0);
    q.delete();
    ready_mode = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_draw(16'h0300, 100, 100, 0, 0, 16'h0000, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
